// File: rtl/alu_pkg.sv
// Operation class and operation codes shared by the ALU datapath and its users.
package alu_pkg;

    localparam logic [2:0] ALU_OP   = 3'd0;
    localparam logic [2:0] SHIFT_OP = 3'd1;
    localparam logic [2:0] LOAD_OP  = 3'd2;

    localparam logic [2:0] ADD_OP  = 3'd0;
    localparam logic [2:0] ADC_OP  = 3'd1;
    localparam logic [2:0] SUB_OP  = 3'd2;
    localparam logic [2:0] SBC_OP  = 3'd3;
    localparam logic [2:0] AND_OP  = 3'd4;
    localparam logic [2:0] OR_OP   = 3'd5;
    localparam logic [2:0] XOR_OP  = 3'd6;
    localparam logic [2:0] NOT_OP  = 3'd7;

    localparam logic [2:0] SHL_OP  = 3'd0;
    localparam logic [2:0] SHR_OP  = 3'd1;
    localparam logic [2:0] ASHR_OP = 3'd2;
    localparam logic [2:0] ROL_OP  = 3'd3;
    localparam logic [2:0] ROR_OP  = 3'd4;

    localparam logic [2:0] COPY_OP = 3'd0;
    localparam logic [2:0] SWAP_OP = 3'd1;
    localparam logic [2:0] LDL_OP  = 3'd2;
    localparam logic [2:0] LDH_OP  = 3'd3;

endpackage

// File: rtl/alu16_comb.sv
// Purely combinational result and flag generator for the 16-bit ALU.
module alu16_comb
    import alu_pkg::*;
(
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    input  logic        carry_i,
    input  logic [2:0]  op_type_i,
    input  logic [2:0]  op_i,
    output logic [15:0] result_o,
    output logic        carry_o,
    output logic        zero_o,
    output logic        negative_o
);

    logic [16:0] sum;

    always_comb begin
        sum      = 17'd0;
        result_o = a_i;
        carry_o  = carry_i;
        case (op_type_i)
            ALU_OP: begin
                case (op_i)
                    ADD_OP: sum = {1'b0, a_i} + {1'b0, b_i};
                    ADC_OP: sum = {1'b0, a_i} + {1'b0, b_i} + {16'd0, carry_i};
                    SUB_OP: sum = {1'b0, a_i} + {1'b0, ~b_i} + 17'd1;
                    SBC_OP: sum = {1'b0, a_i} + {1'b0, ~b_i} + {16'd0, carry_i};
                    default: sum = 17'd0;
                endcase
                // Arithmetic codes take result/carry from the 17-bit sum; logic codes clear carry.
                case (op_i)
                    AND_OP: begin result_o = a_i & b_i; carry_o = 1'b0; end
                    OR_OP:  begin result_o = a_i | b_i; carry_o = 1'b0; end
                    XOR_OP: begin result_o = a_i ^ b_i; carry_o = 1'b0; end
                    NOT_OP: begin result_o = ~a_i;      carry_o = 1'b0; end
                    default: begin result_o = sum[15:0]; carry_o = sum[16]; end
                endcase
            end
            SHIFT_OP: begin
                case (op_i)
                    SHL_OP:  begin result_o = {a_i[14:0], 1'b0};     carry_o = a_i[15]; end
                    SHR_OP:  begin result_o = {1'b0, a_i[15:1]};     carry_o = a_i[0];  end
                    ASHR_OP: begin result_o = {a_i[15], a_i[15:1]};  carry_o = a_i[0];  end
                    ROL_OP:  begin result_o = {a_i[14:0], carry_i};  carry_o = a_i[15]; end
                    ROR_OP:  begin result_o = {carry_i, a_i[15:1]};  carry_o = a_i[0];  end
                    default: begin result_o = a_i;                   carry_o = carry_i; end
                endcase
            end
            LOAD_OP: begin
                case (op_i)
                    SWAP_OP: result_o = {a_i[7:0], a_i[15:8]};
                    LDL_OP:  result_o = {8'h00, a_i[7:0]};
                    LDH_OP:  result_o = {8'h00, a_i[15:8]};
                    default: result_o = a_i;
                endcase
            end
            default: begin
                result_o = a_i;
                carry_o  = carry_i;
            end
        endcase
    end

    assign zero_o     = (result_o == 16'd0);
    assign negative_o = result_o[15];

endmodule

// File: rtl/alu16.sv
// 16-bit ALU: combinational core followed by one output register stage.
module alu16
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic [15:0] operand1,
    input  logic [15:0] operand2,
    input  logic        carryIn,
    input  logic [2:0]  operationType,
    input  logic [2:0]  operation,
    output logic [15:0] result,
    output logic        carryOut,
    output logic        zeroOut,
    output logic        negativeOut
);

    logic [15:0] result_d, result_q;
    logic        carry_d, carry_q;
    logic        zero_d, zero_q;
    logic        neg_d, neg_q;

    alu16_comb u_comb (
        .a_i        (operand1),
        .b_i        (operand2),
        .carry_i    (carryIn),
        .op_type_i  (operationType),
        .op_i       (operation),
        .result_o   (result_d),
        .carry_o    (carry_d),
        .zero_o     (zero_d),
        .negative_o (neg_d)
    );

    // Write-back register; the reset value reads as "no result, all flags clear".
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            result_q <= 16'd0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
        end
    end

    assign result      = result_q;
    assign carryOut    = carry_q;
    assign zeroOut     = zero_q;
    assign negativeOut = neg_q;

endmodule

// File: tb/tb_alu16.sv
// Bench for alu16: directed vector table, reset/hold sequences, random vs. arithmetic model.
module tb_alu16;

    logic        clk;
    logic        resetN;
    logic [15:0] operand1;
    logic [15:0] operand2;
    logic        carryIn;
    logic [2:0]  operationType;
    logic [2:0]  operation;
    logic [15:0] result;
    logic        carryOut;
    logic        zeroOut;
    logic        negativeOut;

    int total = 0;
    int bad   = 0;

    alu16 dut (
        .clk           (clk),
        .resetN        (resetN),
        .operand1      (operand1),
        .operand2      (operand2),
        .carryIn       (carryIn),
        .operationType (operationType),
        .operation     (operation),
        .result        (result),
        .carryOut      (carryOut),
        .zeroOut       (zeroOut),
        .negativeOut   (negativeOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  t;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] r;
        logic        co;
        logic        z;
        logic        n;
    } vec_t;

    vec_t vecs[$];

    // Reference model written from the operation rules with integer arithmetic.
    function automatic logic [18:0] model(input logic [2:0] t, input logic [2:0] op,
                                          input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
        int ai, bi, ci, s, r;
        logic co;
        ai = int'(a); bi = int'(b); ci = c ? 1 : 0;
        r = ai; co = c; s = 0;
        if (t == 3'd0) begin
            case (op)
                3'd0: s = ai + bi;
                3'd1: s = ai + bi + ci;
                3'd2: s = ai + (65535 - bi) + 1;
                3'd3: s = ai + (65535 - bi) + ci;
                default: s = 0;
            endcase
            case (op)
                3'd4: begin r = ai & bi; co = 1'b0; end
                3'd5: begin r = ai | bi; co = 1'b0; end
                3'd6: begin r = ai ^ bi; co = 1'b0; end
                3'd7: begin r = 65535 - ai; co = 1'b0; end
                default: begin r = s % 65536; co = (s >= 65536); end
            endcase
        end else if (t == 3'd1) begin
            case (op)
                3'd0: begin r = (ai * 2) % 65536; co = (ai >= 32768); end
                3'd1: begin r = ai / 2; co = (ai % 2 == 1); end
                3'd2: begin r = ai / 2 + ((ai >= 32768) ? 32768 : 0); co = (ai % 2 == 1); end
                3'd3: begin r = (ai * 2) % 65536 + ci; co = (ai >= 32768); end
                3'd4: begin r = ai / 2 + ci * 32768; co = (ai % 2 == 1); end
                default: begin r = ai; co = c; end
            endcase
        end else if (t == 3'd2) begin
            co = c;
            case (op)
                3'd1: r = (ai % 256) * 256 + ai / 256;
                3'd2: r = ai % 256;
                3'd3: r = ai / 256;
                default: r = ai;
            endcase
        end
        return {r[15:0], co, (r == 0), (r >= 32768)};
    endfunction

    task automatic drive(input logic [2:0] t, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b, input logic c);
        operationType = t;
        operation     = op;
        operand1      = a;
        operand2      = b;
        carryIn       = c;
    endtask

    task automatic check(input string name, input logic [15:0] r, input logic co,
                         input logic z, input logic n);
        total++;
        if ({result, carryOut, zeroOut, negativeOut} !== {r, co, z, n}) begin
            bad++;
            $display("FAIL %s: got r=%h c=%b z=%b n=%b, expected r=%h c=%b z=%b n=%b",
                     name, result, carryOut, zeroOut, negativeOut, r, co, z, n);
        end
    endtask

    // Drive between edges, let one rising edge load, sample 1 ns later.
    task automatic run_vec(input vec_t v);
        @(negedge clk);
        drive(v.t, v.op, v.a, v.b, v.c);
        @(posedge clk);
        #1;
        check(v.name, v.r, v.co, v.z, v.n);
    endtask

    logic [18:0] exp_v;
    logic [2:0]  rt, rop;
    logic [15:0] ra, rb;
    logic        rc;

    initial begin
        vecs.push_back('{"adc",     3'd0, 3'd1, 16'h000A, 16'h000F, 1'b1, 16'h001A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"add_c",   3'd0, 3'd0, 16'hF000, 16'h1243, 1'b0, 16'h0243, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"add_wrap",3'd0, 3'd0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"add_cin", 3'd0, 3'd0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"sub_neg", 3'd0, 3'd2, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{"sub_pos", 3'd0, 3'd2, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"sub_eq",  3'd0, 3'd2, 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0});
        vecs.push_back('{"sbc_c0",  3'd0, 3'd3, 16'h0007, 16'h0005, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"shl_c0",  3'd1, 3'd0, 16'h8234, 16'h0000, 1'b0, 16'h0468, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"shl_c1",  3'd1, 3'd0, 16'h8234, 16'h0000, 1'b1, 16'h0468, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ashr",    3'd1, 3'd2, 16'h8235, 16'h0000, 1'b0, 16'hC11A, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"shr",     3'd1, 3'd1, 16'h8234, 16'h0000, 1'b1, 16'h411A, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"rol_c0",  3'd1, 3'd3, 16'h8235, 16'h0000, 1'b0, 16'h046A, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"rol_c1",  3'd1, 3'd3, 16'h8235, 16'h0000, 1'b1, 16'h046B, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ror_c0",  3'd1, 3'd4, 16'h8235, 16'h0000, 1'b0, 16'h411A, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ror_c1",  3'd1, 3'd4, 16'h8235, 16'h0000, 1'b1, 16'hC11A, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"shift_rsv",3'd1,3'd6, 16'h8235, 16'h0000, 1'b1, 16'h8235, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"not",     3'd0, 3'd7, 16'h8235, 16'hFFFF, 1'b0, 16'h7DCA, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"and",     3'd0, 3'd4, 16'h8235, 16'h00F0, 1'b1, 16'h0030, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{"xor_z",   3'd0, 3'd6, 16'hA5A5, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{"copy",    3'd2, 3'd0, 16'h8235, 16'h1111, 1'b1, 16'h8235, 1'b1, 1'b0, 1'b1});
        vecs.push_back('{"swap",    3'd2, 3'd1, 16'h8235, 16'h1111, 1'b1, 16'h3582, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ldl",     3'd2, 3'd2, 16'h8235, 16'h1111, 1'b1, 16'h0035, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"ldh",     3'd2, 3'd3, 16'h8235, 16'h1111, 1'b1, 16'h0082, 1'b1, 1'b0, 1'b0});
        vecs.push_back('{"rsv_type",3'd5, 3'd0, 16'h1234, 16'hFFFF, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0});

        // Reset asserted with arbitrary inputs clears outputs without a clock edge.
        resetN = 1'b1;
        drive(3'd0, 3'd0, 16'hFFFF, 16'hFFFF, 1'b1);
        #1 resetN = 1'b0;
        #2;
        check("reset_async", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        drive(3'd0, 3'd0, 16'h0001, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        check("first_add", 16'h0002, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Inputs changed mid-cycle must not reach the outputs until the next edge.
        run_vec('{"hold_pre", 3'd0, 3'd0, 16'h1000, 16'h0234, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0});
        #1 drive(3'd0, 3'd7, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        #1;
        check("hold_mid", 16'h1234, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("hold_post", 16'hFFFF, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an operation, then recovery on the next edge.
        run_vec('{"pre_rst", 3'd2, 3'd0, 16'h8001, 16'h0000, 1'b1, 16'h8001, 1'b1, 1'b0, 1'b1});
        #2 resetN = 1'b0;
        #1;
        check("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetN = 1'b1;
        drive(3'd0, 3'd0, 16'hFFFF, 16'h0001, 1'b0);
        @(posedge clk);
        #1;
        check("post_rst", 16'h0000, 1'b1, 1'b1, 1'b0);

        for (int k = 0; k < 400; k++) begin
            rt  = (k % 4 == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            rc  = 1'($urandom);
            if (k % 16 == 0) ra = 16'hFFFF;
            if (k % 16 == 1) rb = ra;
            exp_v = model(rt, rop, ra, rb, rc);
            @(negedge clk);
            drive(rt, rop, ra, rb, rc);
            @(posedge clk);
            #1;
            check($sformatf("rand t=%0d op=%0d a=%h b=%h c=%b", rt, rop, ra, rb, rc),
                  exp_v[18:3], exp_v[2], exp_v[1], exp_v[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
